// File: rtl/mux_nway_pipe_pkg.sv
// Shared constants for mux_nway_pipe: mode encodings and lock FSM states.
package mux_nway_pipe_pkg;

    localparam logic MUX_MODE_MANUAL = 1'b0;
    localparam logic MUX_MODE_RR     = 1'b1;

    typedef enum logic {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_st_t;

endpackage

// File: rtl/mux_nway_pipe_rr_pick.sv
// Rotating-priority search: first set req bit at or after ptr, wrapping mod CH.
// Purely combinational; ptr must be below CH.
module mux_nway_pipe_rr_pick
    import mux_nway_pipe_pkg::*;
#(
    parameter int CH    = 4,
    parameter int SEL_W = $clog2(CH)
) (
    input  logic [CH-1:0]    req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [CH-1:0] rot;
    logic [SEL_W:0] sum;

    always_comb begin
        rot     = CH'({req, req} >> ptr);
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        // Scan high to low so the lowest rotated offset wins.
        for (int i = CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum     = {1'b0, ptr} + (SEL_W+1)'(i);
                gnt_vld = 1'b1;
            end
        end
        if (sum >= (SEL_W+1)'(CH)) begin
            sum = sum - (SEL_W+1)'(CH);
        end
        gnt_idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/mux_nway_pipe.sv
// CH:1 stream mux (manual select or round-robin) into one output register; `MUX_LOCK_EN adds packet lock.
// Latency 1 cycle, 1 beat/cycle while out_ready is high.
// Backpressure: a full register with out_ready low holds and drops every in_ready bit.
module mux_nway_pipe
    import mux_nway_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SEL_W = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [CH-1:0]       in_valid,
    output logic [CH-1:0]       in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    input  logic                out_ready
`ifdef MUX_LOCK_EN
    ,
    input  logic [CH-1:0]       in_last,
    output logic                out_last
`endif
);

    // Channel vectors padded to 2**SEL_W so an out-of-range select reads zero.
    localparam int NP = 1 << SEL_W;

    logic [NP-1:0]    vpad;
    logic [WIDTH-1:0] chd [NP];
    logic [SEL_W-1:0] ptr, ptr_nxt, rr_idx, gnt;
    logic             rr_vld, gnt_vld, load, xfer, adv;

    assign vpad = NP'(in_valid);

    for (genvar i = 0; i < NP; i++) begin : g_chd
        if (i < CH) begin : g_ch
            assign chd[i] = in_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chd[i] = '0;
        end
    end

    mux_nway_pipe_rr_pick #(.CH(CH), .SEL_W(SEL_W)) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

`ifdef MUX_LOCK_EN
    lock_st_t         lock_st;
    logic [SEL_W-1:0] lock_ch;
    logic [NP-1:0]    lpad;

    assign lpad = NP'(in_last);
`endif

    always_comb begin
        gnt     = sel;
        gnt_vld = vpad[sel];
        if (mode == MUX_MODE_RR) begin
            gnt     = rr_idx;
            gnt_vld = rr_vld;
        end
`ifdef MUX_LOCK_EN
        if (lock_st == LK_LOCKED) begin
            gnt     = lock_ch;
            gnt_vld = vpad[lock_ch];
        end
`endif
    end

    assign load     = !out_valid || out_ready;
    assign xfer     = load && gnt_vld && !rst;
    assign in_ready = xfer ? (CH'(1) << gnt) : '0;
    assign ptr_nxt  = (gnt == SEL_W'(CH - 1)) ? '0 : gnt + 1'b1;

`ifdef MUX_LOCK_EN
    // Round-robin moves on only at packet boundaries.
    assign adv = xfer && (mode == MUX_MODE_RR) && lpad[gnt];
`else
    assign adv = xfer && (mode == MUX_MODE_RR);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= chd[gnt];
                out_ch    <= gnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (adv) begin
                ptr <= ptr_nxt;
            end
        end
    end

`ifdef MUX_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_st  <= LK_UNLOCKED;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            out_last <= lpad[gnt];
            case (lock_st)
                LK_UNLOCKED: begin
                    if (!lpad[gnt]) begin
                        lock_st <= LK_LOCKED;
                        lock_ch <= gnt;
                    end
                end
                LK_LOCKED: begin
                    if (lpad[gnt]) begin
                        lock_st <= LK_UNLOCKED;
                    end
                end
                default: lock_st <= LK_UNLOCKED;
            endcase
        end
    end
`endif

endmodule
